// File: rtl/vga_pixel_prefetch.sv
// -----------------------------------------------------------------------------
// vga_pixel_prefetch
// Prefetches pixel words from a frame buffer into a small FIFO so that the VGA
// timing controller can pull one pixel per cycle during the active area.
//
// Ports
//   iCLK         pixel clock (shared with the VGA timing controller)
//   iRST         asynchronous active-high reset
//   iFrameStart  one-cycle pulse at vsync; flushes and restarts the frame
//   iRequest     pixel demand from the VGA controller
//   oRd_Req      frame-buffer read request (held until iRd_Ack)
//   oRd_Addr     frame-buffer word address, valid while oRd_Req is high
//   iRd_Ack      memory accepts the current request
//   iRd_Valid    one returned word valid this cycle (in order)
//   iRd_Data     returned pixel {R[29:20], G[19:10], B[9:0]}
//   oRed/oGreen/oBlue  pixel shown one cycle after a demand (0 when none)
//   oLevel       FIFO occupancy
//   oUnderflow   sticky: a demand found the FIFO empty
// -----------------------------------------------------------------------------
module vga_pixel_prefetch #(
    parameter int DEPTH        = 16,
    parameter int FRAME_PIXELS = 307200,
    parameter int ADDR_W       = 20
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iFrameStart,
    input  logic                     iRequest,
    output logic                     oRd_Req,
    output logic [ADDR_W-1:0]        oRd_Addr,
    input  logic                     iRd_Ack,
    input  logic                     iRd_Valid,
    input  logic [29:0]              iRd_Data,
    output logic [9:0]               oRed,
    output logic [9:0]               oGreen,
    output logic [9:0]               oBlue,
    output logic [$clog2(DEPTH):0]   oLevel,
    output logic                     oUnderflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    // Stale returns can pile up across several back-to-back restarts, so the
    // drop counter gets headroom for 16 full pipelines of abandoned reads.
    localparam int DROP_W = LVL_W + 4;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd_req;
    logic [LVL_W-1:0]    r_outstanding;
    logic [DROP_W-1:0]   r_drop;
    logic [LVL_W-1:0]    r_level;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [29:0]         r_pix;
    logic                r_underflow;
    logic [29:0]         r_mem [DEPTH];

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_rd_req_nxt;
    logic [LVL_W-1:0]    w_outst_nxt;
    logic [DROP_W-1:0]   w_drop_nxt;
    logic [DROP_W-1:0]   w_inflight;
    logic [LVL_W-1:0]    w_level_nxt;
    logic [LVL_W:0]      w_sum;
    logic [PTR_W-1:0]    w_wr_ptr_nxt;
    logic [PTR_W-1:0]    w_rd_ptr_nxt;
    logic [29:0]         w_pix_nxt;
    logic                w_underflow_nxt;
    logic                w_ack;
    logic                w_drop;
    logic                w_keep;
    logic                w_pop;
    logic                w_last_ack;

    // Handshake qualifiers. A return is either discarded (stale read from an
    // abandoned frame) or kept; a return in the restart cycle is always stale.
    always_comb begin
        w_ack      = r_rd_req & iRd_Ack;
        w_drop     = iRd_Valid & ~iFrameStart & (r_drop != '0);
        w_keep     = iRd_Valid & ~iFrameStart & (r_drop == '0)
                     & (r_state != S_IDLE) & (r_outstanding != '0);
        w_pop      = iRequest & ~iFrameStart & (r_level != '0);
        w_last_ack = w_ack & (r_state == S_FETCH) & (r_addr == LAST_ADDR);
    end

    // Next-state and next-value logic for the FSM, counters and FIFO.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_outst_nxt     = r_outstanding;
        w_drop_nxt      = r_drop;
        w_level_nxt     = r_level;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_underflow_nxt = r_underflow;
        w_pix_nxt       = 30'd0;
        w_inflight      = r_drop + DROP_W'(r_outstanding) + DROP_W'(w_ack);

        if (iFrameStart) begin
            w_state_nxt     = S_FETCH;
            w_addr_nxt      = '0;
            w_outst_nxt     = '0;
            w_level_nxt     = '0;
            w_wr_ptr_nxt    = '0;
            w_rd_ptr_nxt    = '0;
            w_underflow_nxt = 1'b0;
            // A return in this very cycle consumes one of the in-flight reads.
            if (iRd_Valid && (w_inflight != '0)) begin
                w_drop_nxt = w_inflight - DROP_W'(1);
            end else begin
                w_drop_nxt = w_inflight;
            end
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_FETCH: w_state_nxt = w_last_ack ? S_DONE : S_FETCH;
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase

            // The final address is held rather than stepped past the frame.
            if (w_ack && !w_last_ack) begin
                w_addr_nxt = r_addr + ADDR_W'(1);
            end else begin
                w_addr_nxt = r_addr;
            end

            case ({w_ack, w_keep})
                2'b10:   w_outst_nxt = r_outstanding + LVL_W'(1);
                2'b01:   w_outst_nxt = r_outstanding - LVL_W'(1);
                default: w_outst_nxt = r_outstanding;
            endcase

            if (w_drop) begin
                w_drop_nxt = r_drop - DROP_W'(1);
            end else begin
                w_drop_nxt = r_drop;
            end

            case ({w_keep, w_pop})
                2'b10:   w_level_nxt = r_level + LVL_W'(1);
                2'b01:   w_level_nxt = r_level - LVL_W'(1);
                default: w_level_nxt = r_level;
            endcase

            if (w_keep) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end

            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
                w_pix_nxt    = r_mem[r_rd_ptr];
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
                w_pix_nxt    = 30'd0;
            end

            if (iRequest && (r_level == '0)) begin
                w_underflow_nxt = 1'b1;
            end else begin
                w_underflow_nxt = r_underflow;
            end
        end

        // Credit check on the values the counters will hold next cycle, so the
        // registered request matches level + outstanding < DEPTH exactly.
        w_sum        = {1'b0, w_level_nxt} + {1'b0, w_outst_nxt};
        w_rd_req_nxt = (w_state_nxt == S_FETCH) && (w_sum < (LVL_W + 1)'(DEPTH));
    end

    // State, counter and output registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_rd_req      <= 1'b0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_level       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pix         <= 30'd0;
            r_underflow   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_rd_req      <= w_rd_req_nxt;
            r_outstanding <= w_outst_nxt;
            r_drop        <= w_drop_nxt;
            r_level       <= w_level_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_pix         <= w_pix_nxt;
            r_underflow   <= w_underflow_nxt;
        end
    end

    // FIFO storage; contents are only read when the level says they are valid.
    always_ff @(posedge iCLK) begin
        if (w_keep) begin
            r_mem[r_wr_ptr] <= iRd_Data;
        end
    end

    assign oRd_Req    = r_rd_req;
    assign oRd_Addr   = r_addr;
    assign oRed       = r_pix[29:20];
    assign oGreen     = r_pix[19:10];
    assign oBlue      = r_pix[9:0];
    assign oLevel     = r_level;
    assign oUnderflow = r_underflow;

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_prefetch
// Self-checking bench: a frame-buffer memory model with random ack and latency,
// a queue-based reference of the prefetcher, a small vector table and directed
// sequences for fill, stream/end-of-frame, starvation, restart and reset.
// -----------------------------------------------------------------------------
module tb_vga_pixel_prefetch;

    localparam int DEPTH = 16;
    localparam int FP    = 1000;
    localparam int AW    = 20;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iFrameStart = 1'b0;
    logic          iRequest = 1'b0;
    logic          iRd_Ack = 1'b0;
    logic          iRd_Valid = 1'b0;
    logic [29:0]   iRd_Data = 30'd0;
    logic          oRd_Req;
    logic [AW-1:0] oRd_Addr;
    logic [9:0]    oRed, oGreen, oBlue;
    logic [LW-1:0] oLevel;
    logic          oUnderflow;

    vga_pixel_prefetch #(.DEPTH(DEPTH), .FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFrameStart(iFrameStart), .iRequest(iRequest),
        .oRd_Req(oRd_Req), .oRd_Addr(oRd_Addr), .iRd_Ack(iRd_Ack),
        .iRd_Valid(iRd_Valid), .iRd_Data(iRd_Data), .oRed(oRed), .oGreen(oGreen),
        .oBlue(oBlue), .oLevel(oLevel), .oUnderflow(oUnderflow)
    );

    always #5 iCLK = ~iCLK;

    // memory model: acknowledged reads waiting to return, tagged with frame epoch
    typedef struct { int addr; int due; int epoch; } rd_t;
    rd_t mem_q[$];

    // reference model
    logic [29:0] m_fifo[$];
    logic [29:0] m_pix;
    int  m_epoch;
    int  m_addr;
    bit  m_fetch;
    bit  m_idle;
    bit  m_uf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ack_seen = 0;
    int ack_pct = 0;
    int lat_min = 1;
    int lat_max = 1;
    int req_pct = 0;

    typedef struct {
        logic          fs;
        logic          req;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_level;
        logic          e_uf;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [29:0] pix_of(input int a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E37_79B1 + 32'h0123_4567;
        return h[29:0];
    endfunction

    function automatic int m_outst();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch == m_epoch) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_pix   = 30'd0;
        m_epoch = m_epoch + 1;
        m_addr  = 0;
        m_fetch = 1'b0;
        m_idle  = 1'b1;
        m_uf    = 1'b0;
    endtask

    task automatic compare_outputs();
        bit exp_req;
        exp_req = m_fetch && ((m_fifo.size() + m_outst()) < DEPTH);
        chk("rd_req", 32'(oRd_Req), 32'(exp_req));
        if (exp_req) chk("rd_addr", 32'(oRd_Addr), 32'(m_addr));
        chk("pixel", {2'b00, oRed, oGreen, oBlue}, {2'b00, m_pix});
        chk("level", 32'(oLevel), 32'(m_fifo.size()));
        chk("underflow", 32'(oUnderflow), 32'(m_uf));
    endtask

    // one clock: memory responds, model follows the edge, outputs compared
    task automatic step();
        bit  keep;
        bit  empty_before;
        rd_t e;
        iRd_Ack   = oRd_Req && (int'($urandom_range(99)) < ack_pct);
        iRd_Valid = 1'b0;
        iRd_Data  = 30'd0;
        keep      = 1'b0;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc) begin
                iRd_Valid = 1'b1;
                iRd_Data  = pix_of(mem_q[0].addr);
                keep      = !iFrameStart && !m_idle && (mem_q[0].epoch == m_epoch);
            end
        end
        @(posedge iCLK);
        if (iRd_Valid) mem_q.delete(0);
        if (!iRST) begin
            empty_before = (m_fifo.size() == 0);
            if (iRequest && !iFrameStart && !empty_before) m_pix = m_fifo.pop_front();
            else m_pix = 30'd0;
            if (iRequest && empty_before) m_uf = 1'b1;
            if (keep) m_fifo.push_back(iRd_Data);
            if (iRd_Ack) begin
                e.addr  = m_addr;
                e.epoch = m_epoch;
                e.due   = cyc + int'($urandom_range(lat_max, lat_min));
                if (mem_q.size() > 0 && e.due <= mem_q[$].due) e.due = mem_q[$].due + 1;
                mem_q.push_back(e);
                ack_seen++;
                if (m_addr == FP - 1) m_fetch = 1'b0;
                else m_addr++;
            end
            if (iFrameStart) begin
                m_fifo.delete();
                m_epoch++;
                m_fetch  = 1'b1;
                m_idle   = 1'b0;
                m_addr   = 0;
                m_uf     = 1'b0;
                m_pix    = 30'd0;
                ack_seen = 0;
            end
        end
        @(negedge iCLK);
        cyc++;
        compare_outputs();
    endtask

    task automatic frame_start();
        iFrameStart = 1'b1;
        step();
        iFrameStart = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        m_epoch = 0;
        model_reset();
        vecs[0] = '{1'b0, 1'b0, 1'b0, 20'd0, 5'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 20'd0, 5'd0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 20'd0, 5'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 20'd0, 5'd0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 20'd0, 5'd0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 20'd0, 5'd0, 1'b0};

        // reset state
        @(negedge iCLK);
        compare_outputs();
        chk("reset_addr", 32'(oRd_Addr), 32'd0);
        run(2);
        iRST = 1'b0;

        // vector table, memory silent
        ack_pct = 0;
        for (int i = 0; i < 6; i++) begin
            iFrameStart = vecs[i].fs;
            iRequest    = vecs[i].req;
            step();
            chk("tbl_req", 32'(oRd_Req), 32'(vecs[i].e_req));
            chk("tbl_addr", 32'(oRd_Addr), 32'(vecs[i].e_addr));
            chk("tbl_level", 32'(oLevel), 32'(vecs[i].e_level));
            chk("tbl_uf", 32'(oUnderflow), 32'(vecs[i].e_uf));
            chk("tbl_pix", {2'b00, oRed, oGreen, oBlue}, 32'd0);
        end
        iFrameStart = 1'b0;
        iRequest    = 1'b0;

        // fill: immediate ack, 3-cycle return
        ack_pct = 100; lat_min = 3; lat_max = 3;
        frame_start();
        run(40);
        chk("fill_acks", 32'(ack_seen), 32'd16);
        chk("fill_level", 32'(oLevel), 32'd16);
        chk("fill_req", 32'(oRd_Req), 32'd0);

        // stream 640 pixels with zero-wait memory, then run to end of frame
        lat_min = 1; lat_max = 1;
        iRequest = 1'b1;
        step();
        chk("stream_first", {2'b00, oRed, oGreen, oBlue}, {2'b00, pix_of(0)});
        run(639);
        chk("stream_last", {2'b00, oRed, oGreen, oBlue}, {2'b00, pix_of(639)});
        chk("stream_uf", 32'(oUnderflow), 32'd0);
        for (int g = 0; g < 2000 && ack_seen < FP; g++) step();
        run(40);
        chk("frame_acks", 32'(ack_seen), 32'(FP));
        chk("frame_done_req", 32'(oRd_Req), 32'd0);
        iRequest = 1'b0;

        // starvation: fill, stop the memory, 17 one-cycle demands
        lat_min = 3; lat_max = 3;
        frame_start();
        run(40);
        ack_pct = 0;
        for (int k = 1; k <= 17; k++) begin
            iRequest = 1'b1;
            step();
            chk("starve_pix", {2'b00, oRed, oGreen, oBlue},
                (k <= 16) ? {2'b00, pix_of(k - 1)} : 32'd0);
            if (k == 16) chk("starve_uf16", 32'(oUnderflow), 32'd0);
            iRequest = 1'b0;
            step();
        end
        chk("starve_uf17", 32'(oUnderflow), 32'd1);

        // restart with 5 reads in flight
        frame_start();
        iRequest = 1'b1;
        step();
        iRequest = 1'b0;
        chk("restart_uf_set", 32'(oUnderflow), 32'd1);
        ack_pct = 100; lat_min = 8; lat_max = 8;
        for (int g = 0; g < 20 && m_outst() < 5; g++) step();
        ack_pct = 0;
        chk("restart_pre_level", 32'(oLevel), 32'd0);
        frame_start();
        chk("restart_uf_clr", 32'(oUnderflow), 32'd0);
        for (int g = 0; g < 30 && mem_q.size() > 0; g++) step();
        chk("restart_level", 32'(oLevel), 32'd0);
        chk("restart_req", 32'(oRd_Req), 32'd1);
        chk("restart_addr", 32'(oRd_Addr), 32'd0);
        ack_pct = 100; lat_min = 1; lat_max = 2;
        run(20);

        // randomized traffic with occasional restarts
        for (int blk = 0; blk < 12; blk++) begin
            ack_pct = int'($urandom_range(100, 20));
            lat_min = int'($urandom_range(4, 1));
            lat_max = lat_min + int'($urandom_range(6, 0));
            req_pct = int'($urandom_range(100, 0));
            for (int c = 0; c < 250; c++) begin
                iFrameStart = ($urandom_range(199) == 0);
                iRequest    = (int'($urandom_range(99)) < req_pct);
                step();
            end
        end
        iFrameStart = 1'b0;
        iRequest    = 1'b0;

        // reset mid-frame with a partly full FIFO and reads in flight
        ack_pct = 100; lat_min = 6; lat_max = 6;
        frame_start();
        run(10);
        chk("pre_rst_nonempty", 32'(oLevel != '0), 32'd1);
        #2;
        iRST = 1'b1;
        #1;
        chk("rst_async_req", 32'(oRd_Req), 32'd0);
        chk("rst_async_addr", 32'(oRd_Addr), 32'd0);
        chk("rst_async_level", 32'(oLevel), 32'd0);
        chk("rst_async_pix", {2'b00, oRed, oGreen, oBlue}, 32'd0);
        chk("rst_async_uf", 32'(oUnderflow), 32'd0);
        model_reset();
        @(negedge iCLK);
        run(2);
        iRST = 1'b0;
        for (int c = 0; c < 20; c++) begin
            iRequest = (c % 3 == 0);
            step();
        end
        iRequest = 1'b0;
        chk("post_rst_req", 32'(oRd_Req), 32'd0);
        for (int g = 0; g < 40 && mem_q.size() > 0; g++) step();
        chk("post_rst_level", 32'(oLevel), 32'd0);
        frame_start();
        chk("post_rst_fs_req", 32'(oRd_Req), 32'd1);
        run(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_pixel_prefetch.md
VGA_PIXEL_PREFETCH -- requirements
Module: vga_pixel_prefetch

Interface
REQ-001 Parameter DEPTH, default 16: prefetch FIFO depth in pixel words (power of two, 4..64).
REQ-002 Parameter FRAME_PIXELS, default 307200: pixel reads per frame (640x480).
REQ-003 Parameter ADDR_W, default 20: width of the frame-buffer word address.
REQ-004 Port iCLK, in, 1: pixel clock, shared with the downstream VGA timing controller.
REQ-005 Port iRST, in, 1: reset, asynchronous and active-high.
REQ-006 Port iFrameStart, in, 1: one-cycle pulse at the vertical-sync rising edge; restarts the frame.
REQ-007 Port iRequest, in, 1: pixel demand from the VGA controller, asserted during the active area.
REQ-008 Port oRd_Req, out, 1: frame-buffer read request.
REQ-009 Port oRd_Addr, out, ADDR_W: read word address, valid while oRd_Req is high.
REQ-010 Port iRd_Ack, in, 1: memory accepts the request in the current cycle.
REQ-011 Port iRd_Valid, in, 1: one returned word is valid in the current cycle (in order, arbitrary latency).
REQ-012 Port iRd_Data, in, 30: returned pixel, packed as {R[29:20], G[19:10], B[9:0]}.
REQ-013 Ports oRed, oGreen, oBlue, out, 10 each: pixel to the VGA controller colour inputs.
REQ-014 Port oLevel, out, clog2(DEPTH)+1: current FIFO occupancy.
REQ-015 Port oUnderflow, out, 1: sticky flag, set when a demand finds the FIFO empty.

Function
REQ-016 The block SHALL run a state machine with three states: IDLE, FETCH and DONE.
REQ-017 IDLE SHALL move to FETCH on iFrameStart; no other event leaves IDLE.
REQ-018 FETCH SHALL move to DONE on the cycle the FRAME_PIXELS-th request is acknowledged.
REQ-019 From any state, iFrameStart SHALL force FETCH with the read address set to 0.
REQ-020 oRd_Req SHALL be high only when all hold:
- state is FETCH;
- oLevel + outstanding < DEPTH, where outstanding = acknowledged requests not yet returned.
REQ-021 The read address SHALL increment by 1 on each cycle with oRd_Req and iRd_Ack both high.
REQ-022 oRd_Req and oRd_Addr SHALL stay stable until iRd_Ack.
REQ-023 The outstanding counter SHALL:
- increment on an acknowledge;
- decrement on a kept return;
- stay unchanged when both occur in the same cycle.
REQ-024 A kept return (iRd_Valid) SHALL be pushed into the FIFO.
REQ-025 By construction the FIFO never overflows; a push to a full FIFO is a design error and an assertion target.
REQ-026 On iFrameStart the block SHALL:
- empty the FIFO;
- load a drop counter with all in-flight returns, including an acknowledge in that same cycle;
- clear outstanding.
REQ-027 While the drop counter is nonzero, each iRd_Valid SHALL be discarded and SHALL decrement the drop counter.
REQ-028 An iRd_Valid in the same cycle as iFrameStart SHALL be discarded and excluded from the drop count.
REQ-029 When iRequest is high and the FIFO is non-empty, the block SHALL pop one word; oRed/oGreen/oBlue SHALL show it on the next cycle (1-cycle latency).
REQ-030 When iRequest is high and the FIFO is empty, the outputs SHALL be 0 on the next cycle and oUnderflow SHALL be set.
REQ-031 When iRequest is low, the outputs SHALL be 0 on the next cycle.
REQ-032 A push and a pop in the same cycle SHALL leave oLevel unchanged, and the popped word SHALL be the oldest entry.
REQ-033 When iFrameStart and iRequest occur in the same cycle, the flush SHALL win: no pop, outputs 0.
REQ-034 oUnderflow SHALL clear only on iFrameStart or reset.
REQ-035 The address and all counters SHALL wrap nowhere: the address range is 0..FRAME_PIXELS-1.

Reset
REQ-036 While iRST is high, the block SHALL hold:
- state IDLE;
- oRd_Req=0 and oRd_Addr=0;
- FIFO empty and oLevel=0;
- outstanding and drop counters at 0;
- oRed/oGreen/oBlue=0;
- oUnderflow=0.
REQ-037 Reset mid-frame SHALL abandon in-flight reads; returns arriving after reset release, before any iFrameStart, SHALL be ignored because the state is IDLE.

Verification
REQ-038 Fill scenario: iFrameStart, then a memory with 1-cycle ack and 3-cycle return latency -> requests at addresses 0..15, then oRd_Req low, oLevel=16, outstanding 0.
REQ-039 Stream scenario: iRequest high for 640 cycles with zero-wait memory -> output pixels equal the data for addresses 0..639 in order, each delayed by 1 cycle; oUnderflow=0.
REQ-040 Starvation scenario: iRd_Ack held low, then iRequest pulsed 17 times -> the first 16 pulses return the stored pixels, the 17th returns 0, and oUnderflow=1.
REQ-041 Mid-flight restart: iFrameStart with 5 reads outstanding -> the next 5 iRd_Valid are dropped, FIFO empty, next request at address 0; oUnderflow cleared.
REQ-042 End of frame: FRAME_PIXELS=8 -> exactly 8 acknowledged requests, then DONE with oRd_Req=0 until the next iFrameStart.
REQ-043 Reset mid-frame: assert iRST with a partly full FIFO -> all outputs read 0 immediately (asynchronously); after release, no request is issued until iFrameStart.
